// File: rtl/vga_scan_engine.sv
// vga_scan_engine
//   Parametrised VGA scan-timing and display path running from one system
//   clock qualified by a pixel-enable tick. Frame-buffer fetch coordinates
//   lead the beam by LOOKAHEAD ticks and are downscaled by 2**SCALE_SHIFT.
//   The returned colour is reduced to 4 bits per channel and registered
//   together with sync and blank.
//
// Optional feature: define VGA_SCAN_DITHER_EN to enable a 2x2 ordered dither
//   on each channel (only meaningful when COLOR_IN_W > 4). Without it each
//   channel is plain truncation to its top 4 bits.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   pix_en      pixel tick; all state advances only on edges with pix_en=1
//   pixel_data  {R,G,B}, COLOR_IN_W bits each, for the coordinate fetched
//               LOOKAHEAD ticks earlier
//   fetch_x/y   scaled fetch column/row (combinational from the counters)
//   fetch_valid fetch position is inside the visible area
//   frame_end   one pix_en tick per frame, at the last visible fetch pixel
//   vblank      fetch row is at or beyond V_DISPLAY
//   hsync/vsync registered sync, SYNC_ACTIVE during the pulse
//   blank       registered, 1 while the beam is outside the visible area
//   vga_red/green/blue  registered 4-bit colour, 0 while blanked
module vga_scan_engine #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   SCALE_SHIFT = 1,
  parameter int   LOOKAHEAD   = 2,
  parameter int   COLOR_IN_W  = 6,
  parameter logic SYNC_ACTIVE = 1'b1,
  localparam int  H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int  HC_W        = $clog2(H_TOTAL),
  localparam int  VC_W        = $clog2(V_TOTAL)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pix_en,
  input  logic [3*COLOR_IN_W-1:0]       pixel_data,
  output logic [HC_W-SCALE_SHIFT-1:0]   fetch_x,
  output logic [VC_W-SCALE_SHIFT-1:0]   fetch_y,
  output logic                          fetch_valid,
  output logic                          frame_end,
  output logic                          vblank,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          blank,
  output logic [3:0]                    vga_red,
  output logic [3:0]                    vga_green,
  output logic [3:0]                    vga_blue
);

  // Bit positions inside one delay-line stage.
  localparam int VS_B  = 0;
  localparam int HS_B  = 1;
  localparam int ACT_B = 2;
`ifdef VGA_SCAN_DITHER_EN
  localparam int Y0_B    = 3;
  localparam int X0_B    = 4;
  localparam int STAGE_W = 5;
`else
  localparam int STAGE_W = 3;
`endif

  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC - 1;

  // ---------------------------------------------------------------------
  // Fetch counters
  // ---------------------------------------------------------------------
  logic [HC_W-1:0] hc_reg;
  logic [VC_W-1:0] vc_reg;
  logic            hc_wrap;
  logic            vc_wrap;
  logic            active;
  logic            hs;
  logic            vs;

  assign hc_wrap = (hc_reg == HC_W'(H_TOTAL - 1));
  assign vc_wrap = (vc_reg == VC_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_reg <= '0;
      vc_reg <= '0;
    end else if (pix_en) begin
      if (hc_wrap) begin
        hc_reg <= '0;
        if (vc_wrap) vc_reg <= '0;
        else         vc_reg <= vc_reg + 1'b1;
      end else begin
        hc_reg <= hc_reg + 1'b1;
      end
    end
  end

  assign active = (hc_reg < HC_W'(H_DISPLAY)) && (vc_reg < VC_W'(V_DISPLAY));
  assign hs     = (hc_reg >= HC_W'(HS_START)) && (hc_reg <= HC_W'(HS_END));
  assign vs     = (vc_reg >= VC_W'(VS_START)) && (vc_reg <= VC_W'(VS_END));

  assign fetch_x     = hc_reg[HC_W-1:SCALE_SHIFT];
  assign fetch_y     = vc_reg[VC_W-1:SCALE_SHIFT];
  assign fetch_valid = active;
  assign vblank      = (vc_reg >= VC_W'(V_DISPLAY));
  // Combinational so it is high only on the enabled tick itself.
  assign frame_end   = pix_en && (hc_reg == HC_W'(H_DISPLAY - 1))
                              && (vc_reg == VC_W'(V_DISPLAY - 1));

  // ---------------------------------------------------------------------
  // Delay line: aligns beam attributes with the returning pixel data
  // ---------------------------------------------------------------------
  logic [LOOKAHEAD-1:0][STAGE_W-1:0] stage_reg;
  logic [STAGE_W-1:0]                stage_in;
  logic [STAGE_W-1:0]                stage_out;

`ifdef VGA_SCAN_DITHER_EN
  assign stage_in = {hc_reg[0], vc_reg[0], active, hs, vs};
`else
  assign stage_in = {active, hs, vs};
`endif
  assign stage_out = stage_reg[LOOKAHEAD-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else if (pix_en) begin
      stage_reg[0] <= stage_in;
      for (int i = 1; i < LOOKAHEAD; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Colour conversion (index 0 = red, 1 = green, 2 = blue)
  // ---------------------------------------------------------------------
  logic [2:0][3:0] color_conv;

`ifdef VGA_SCAN_DITHER_EN
  // 2x2 Bayer threshold from the unscaled beam position.
  logic [1:0] dither_th;
  assign dither_th = {stage_out[X0_B] ^ stage_out[Y0_B], stage_out[Y0_B]};
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [COLOR_IN_W-1:0] field;
      logic [3:0]            top4;

      assign field = pixel_data[(3-gi)*COLOR_IN_W-1 -: COLOR_IN_W];
      assign top4  = field[COLOR_IN_W-1 -: 4];

`ifdef VGA_SCAN_DITHER_EN
      if (COLOR_IN_W > 4) begin : g_dither
        logic [1:0] low;
        if (COLOR_IN_W >= 6) begin : g_wide
          // Only the two most significant residual bits feed the compare.
          assign low = field[COLOR_IN_W-5 -: 2];
          if (COLOR_IN_W > 6) begin : g_drop
            logic unused_bits;
            assign unused_bits = ^field[COLOR_IN_W-7:0];
          end
        end else begin : g_narrow
          assign low = {1'b0, field[0]};
        end
        // Saturate at full scale so 15 never rolls over to 0.
        assign color_conv[gi] = (top4 == 4'hF) ? 4'hF
                              : top4 + {3'b000, (low > dither_th)};
      end else begin : g_plain
        assign color_conv[gi] = top4;
      end
`else
      assign color_conv[gi] = top4;
      if (COLOR_IN_W > 4) begin : g_drop
        logic unused_bits;
        assign unused_bits = ^field[COLOR_IN_W-5:0];
      end
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync     <= ~SYNC_ACTIVE;
      vsync     <= ~SYNC_ACTIVE;
      blank     <= 1'b1;
      vga_red   <= 4'h0;
      vga_green <= 4'h0;
      vga_blue  <= 4'h0;
    end else if (pix_en) begin
      hsync <= stage_out[HS_B] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync <= stage_out[VS_B] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      blank <= ~stage_out[ACT_B];
      if (stage_out[ACT_B]) begin
        vga_red   <= color_conv[0];
        vga_green <= color_conv[1];
        vga_blue  <= color_conv[2];
      end else begin
        vga_red   <= 4'h0;
        vga_green <= 4'h0;
        vga_blue  <= 4'h0;
      end
    end
  end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
Parametrised successor to the fixed 640x480 VGA timing and display path. It generates scan timing from a single system clock qualified by a pixel-enable tick, so no derived clock is needed. It issues frame-buffer fetch coordinates a configurable number of ticks ahead of the beam, downscaled by a power of two. It converts the returned pixel colour into registered 4-bit-per-channel VGA outputs with correct blanking and sync.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, front porch (pixels)
H_SYNC, 96, sync pulse width (pixels)
H_BACK, 48, back porch (pixels)
V_DISPLAY, 480, visible lines
V_FRONT, 10, front porch (lines)
V_SYNC, 2, sync pulse width (lines)
V_BACK, 33, back porch (lines)
SCALE_SHIFT, 1, fetch coordinate = beam coordinate >> SCALE_SHIFT (0..3)
LOOKAHEAD, 2, pix_en ticks between fetch coordinate and beam (1..4)
COLOR_IN_W, 6, bits per channel of pixel_data (4..8)
SYNC_ACTIVE, 1, level driven on hsync/vsync during the pulse

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  pixel tick; all state advances only on clk edges with pix_en=1
pixel_data  in  3*COLOR_IN_W  {R,G,B} for the coordinate fetched LOOKAHEAD ticks earlier
fetch_x  out  HC_W-SCALE_SHIFT  scaled fetch column; HC_W=$clog2(H_TOTAL)
fetch_y  out  VC_W-SCALE_SHIFT  scaled fetch row; VC_W=$clog2(V_TOTAL)
fetch_valid  out  1  fetch position lies inside the visible area
frame_end  out  1  high for exactly one pix_en tick per frame
vblank  out  1  fetch row >= V_DISPLAY
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
blank  out  1  registered; 1 when the beam is outside the visible area
vga_red  out  4  registered red
vga_green  out  4  registered green
vga_blue  out  4  registered blue

Behaviour:
- H_TOTAL = sum of the four H parameters (default 800). V_TOTAL = sum of the four V parameters (default 525).
- Fetch counters hc, vc:
  - hc wraps H_TOTAL-1 -> 0.
  - vc increments when hc wraps, and itself wraps V_TOTAL-1 -> 0.
  - fetch_x = hc>>SCALE_SHIFT and fetch_y = vc>>SCALE_SHIFT, combinational from the counters, valid in blanking too.
  - fetch_valid = hc<H_DISPLAY && vc<V_DISPLAY.
- Delay line: LOOKAHEAD stages, each carrying {hc[0], vc[0], active, hs, vs}, advance on pix_en.
  - hs is true for hc in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
  - vs is true for vc in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- Output register updates on pix_en from the last delay stage:
  - hsync/vsync = SYNC_ACTIVE when hs/vs are set, else ~SYNC_ACTIVE.
  - blank = ~active.
  - RGB = 0 when not active, else the colour-converted pixel_data sampled on that same edge.
- Timing contract: a coordinate presented at tick t must have its data stable on pixel_data at tick t+LOOKAHEAD. Its colour is visible on the outputs after that edge.
- frame_end is asserted while hc==H_DISPLAY-1, vc==V_DISPLAY-1 and pix_en=1; it is 0 otherwise.
- pix_en=0: every register holds; frame_end is 0.
- Colour conversion, without dither: each channel = top 4 bits of its COLOR_IN_W field.
- Reset values (asynchronous):
  - hc=vc=0; all delay stages cleared to inactive, no sync.
  - hsync=vsync=~SYNC_ACTIVE, blank=1, RGB=0, frame_end=0.
  - Reset mid-frame aborts the frame. Scan restarts from (0,0) on the first pix_en after release, and the first visible output appears LOOKAHEAD ticks later.

Optional Feature:
Macro VGA_SCAN_DITHER_EN.
- Defined:
  - 2x2 ordered dither applied to each channel when COLOR_IN_W>4.
  - Threshold th = {beam_y[0]^beam_x[0], beam_y[0]}, using the unscaled beam LSBs from the delay line.
  - low = field bits [COLOR_IN_W-5:0], taken as the top two of those bits when wider than 2.
  - out = (top4==15) ? 15 : top4 + (low > th).
- Not defined: plain truncation; the beam LSBs are not carried in the delay line.

Test Plan:
- Reset asserted, then released with pix_en=1 every cycle -> outputs hold reset values until the first edge. fetch=(0,0), fetch_valid=1, and blank stays 1 for 2 ticks (LOOKAHEAD=2).
- Free run, defaults -> frame_end pulses exactly 420000 ticks apart.
- Free run, defaults -> hsync=1 for 96 ticks per line, starting at beam x=656; vsync=1 for 2 lines starting at beam y=490.
- Model drives pixel_data = {x[5:0],y[5:0],6'h3F} from the fetch seen 2 ticks earlier -> at beam (10,4): red=4'd1, green=4'd0, blue=15. Blank ticks give RGB=0.
- pix_en high one cycle in four -> counter, sync and RGB sequence identical to the free run, just stretched ×4. Reset at beam (300,200) -> restarts from (0,0).
- VGA_SCAN_DITHER_EN, red field 6'b000110:
  - beam (0,0) -> 2; (1,0) -> 1; (0,1) -> 1; (1,1) -> 2.
  - field 6'h3F -> 15 at every position.
